// File: rtl/alu_muldiv_pipe_pkg.sv
// Shared op-code values and the multiply/divide sequencer state encoding
// for the execute-stage ALU.
package alu_pkg;

    localparam logic [3:0] OP_SLL   = 4'd0;
    localparam logic [3:0] OP_SRL   = 4'd1;
    localparam logic [3:0] OP_SRA   = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_AND   = 4'd5;
    localparam logic [3:0] OP_OR    = 4'd6;
    localparam logic [3:0] OP_XOR   = 4'd7;
    localparam logic [3:0] OP_NOR   = 4'd8;
    localparam logic [3:0] OP_SLT   = 4'd9;
    localparam logic [3:0] OP_SLTU  = 4'd10;
    localparam logic [3:0] OP_MULT  = 4'd11;
    localparam logic [3:0] OP_MULTU = 4'd12;
    localparam logic [3:0] OP_DIV   = 4'd13;
    localparam logic [3:0] OP_DIVU  = 4'd14;
    localparam logic [3:0] OP_RSVD  = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } md_state_t;

endpackage

// File: rtl/alu_muldiv_pipe_muldiv_iter.sv
// Iterative multiply (shift-add) / divide (restoring) unit working on operand
// magnitudes, with sign fix-up applied combinationally while in DONE.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         is_div,
    input  logic         is_signed,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         done,
    output md_state_t    state,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo,
    output logic         ovf,
    output logic         dbz
);

    localparam int CNT_W = $clog2(N) + 1;
    localparam logic [N-1:0] MIN_NEG  = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0] ALL_ONES = {N{1'b1}};

    md_state_t      state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [2*N-1:0] acc;
    logic [N-1:0]   dvs;
    logic           div_mode, neg_p, neg_q, neg_r, ovf_q, dbz_q;

    logic           a_neg, b_neg;
    logic [N-1:0]   a_mag, b_mag, mul_add, div_rem;
    logic [N:0]     mul_sum, div_shift;
    logic           div_ge;
    logic [2*N-1:0] prod_fix;
    logic [N-1:0]   q_fix, r_fix;

    assign a_neg = is_signed & a[N-1];
    assign b_neg = is_signed & b[N-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    assign mul_add   = acc[0] ? dvs : {N{1'b0}};
    assign mul_sum   = {1'b0, acc[2*N-1:N]} + {1'b0, mul_add};
    assign div_shift = {acc[2*N-1:N], acc[N-1]};
    assign div_ge    = div_shift >= {1'b0, dvs};
    assign div_rem   = div_ge ? N'(div_shift - {1'b0, dvs}) : div_shift[N-1:0];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (is_div && b == '0) state_nxt = DONE;
                    else if (is_div)       state_nxt = DIV;
                    else                   state_nxt = MUL;
                end
            end
            MUL, DIV: if (cnt == '0) state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            dvs      <= '0;
            div_mode <= 1'b0;
            neg_p    <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            ovf_q    <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt      <= CNT_W'(N - 1);
                        div_mode <= is_div;
                        neg_p    <= 1'b0;
                        neg_q    <= 1'b0;
                        neg_r    <= 1'b0;
                        ovf_q    <= 1'b0;
                        dbz_q    <= 1'b0;
                        if (is_div && b == '0) begin
                            // Divide by zero skips iterations; no sign fix-up applies.
                            acc   <= {a, ALL_ONES};
                            dbz_q <= 1'b1;
                        end else if (is_div) begin
                            acc   <= {{N{1'b0}}, a_mag};
                            dvs   <= b_mag;
                            neg_q <= a_neg ^ b_neg;
                            neg_r <= a_neg;
                            ovf_q <= is_signed && a == MIN_NEG && b == ALL_ONES;
                        end else begin
                            acc   <= {{N{1'b0}}, b_mag};
                            dvs   <= a_mag;
                            neg_p <= a_neg ^ b_neg;
                        end
                    end
                end
                MUL: begin
                    acc <= {mul_sum, acc[N-1:1]};
                    cnt <= cnt - CNT_W'(1);
                end
                DIV: begin
                    acc <= {div_rem, acc[N-2:0], div_ge};
                    cnt <= cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign prod_fix = neg_p ? -acc : acc;
    assign q_fix    = neg_q ? -acc[N-1:0] : acc[N-1:0];
    assign r_fix    = neg_r ? -acc[2*N-1:N] : acc[2*N-1:N];

    assign done = (state == DONE);
    assign hi   = div_mode ? r_fix : prod_fix[2*N-1:N];
    assign lo   = div_mode ? q_fix : prod_fix[N-1:0];
    assign ovf  = ovf_q;
    assign dbz  = dbz_q;

endmodule

// File: rtl/alu_muldiv_pipe.sv
// Registered execute-stage ALU: single-cycle integer ops plus an iterative
// multiply/divide unit that writes the HI/LO pair.
module alu_muldiv_pipe
    import alu_pkg::*;
#(
    parameter int N   = 32,
    parameter int SHW = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   op_code,
    input  logic [N-1:0] operand1,
    input  logic [N-1:0] operand2,
    output logic         out_valid,
    output logic [N-1:0] result,
    output logic         zero,
    output logic         overflow,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo,
    output logic         md_busy,
    output logic         div_by_zero
);

    // Handshake: a request is taken at a posedge where in_valid & in_ready;
    // in_ready drops while the mul/div unit is occupied, so requests then are ignored.
    logic           accept, md_start, md_is_div, md_is_signed;
    logic           md_done, md_ovf, md_dbz;
    logic [N-1:0]   md_hi, md_lo;
    md_state_t      md_state;

    logic [N-1:0]   alu_res, sum, dif;
    logic           alu_ovf;
    logic [SHW-1:0] shamt;

    assign md_busy      = (md_state != IDLE);
    assign in_ready     = ~md_busy;
    assign accept       = in_valid & in_ready;
    assign md_start     = accept && (op_code >= OP_MULT) && (op_code <= OP_DIVU);
    assign md_is_div    = (op_code == OP_DIV) || (op_code == OP_DIVU);
    assign md_is_signed = (op_code == OP_MULT) || (op_code == OP_DIV);

    muldiv_iter #(.N(N)) u_muldiv (
        .clk       (clk),
        .reset     (reset),
        .start     (md_start),
        .is_div    (md_is_div),
        .is_signed (md_is_signed),
        .a         (operand1),
        .b         (operand2),
        .done      (md_done),
        .state     (md_state),
        .hi        (md_hi),
        .lo        (md_lo),
        .ovf       (md_ovf),
        .dbz       (md_dbz)
    );

    assign sum   = operand1 + operand2;
    assign dif   = operand1 - operand2;
    assign shamt = operand1[SHW-1:0];

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op_code)
            OP_SLL:  alu_res = operand2 << shamt;
            OP_SRL:  alu_res = operand2 >> shamt;
            OP_SRA:  alu_res = $signed(operand2) >>> shamt;
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (operand1[N-1] == operand2[N-1]) && (sum[N-1] != operand1[N-1]);
            end
            OP_SUB: begin
                alu_res = dif;
                alu_ovf = (operand1[N-1] != operand2[N-1]) && (dif[N-1] != operand1[N-1]);
            end
            OP_AND:  alu_res = operand1 & operand2;
            OP_OR:   alu_res = operand1 | operand2;
            OP_XOR:  alu_res = operand1 ^ operand2;
            OP_NOR:  alu_res = ~(operand1 | operand2);
            OP_SLT:  alu_res = {{(N-1){1'b0}}, $signed(operand1) < $signed(operand2)};
            OP_SLTU: alu_res = {{(N-1){1'b0}}, operand1 < operand2};
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            result      <= '0;
            zero        <= 1'b0;
            overflow    <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (md_done) begin
                out_valid   <= 1'b1;
                hi          <= md_hi;
                lo          <= md_lo;
                result      <= md_lo;
                zero        <= (md_lo == '0);
                overflow    <= md_ovf;
                div_by_zero <= md_dbz;
            end else if (accept && !md_start) begin
                out_valid   <= 1'b1;
                result      <= alu_res;
                zero        <= (alu_res == '0);
                overflow    <= alu_ovf;
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule
